// File: rtl/fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_unit_pkg
// Shared definitions for the instruction-fetch engine:
//   - FSM state encoding (S_IDLE, S_FETCH, S_CAPT, S_HOLD)
//   - instr_width(): instruction width derived from word width and word count
//   - cnt_width():   width of the word-slot counter (never narrower than 1 bit)
// ---------------------------------------------------------------------------
package fetch_unit_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  function automatic int instr_width(input int data_w, input int words);
    return data_w * words;
  endfunction

  // A single-word instruction still needs a 1-bit counter so the slot
  // index and comparisons stay well formed.
  function automatic int cnt_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Program counter register with synchronous reset, load and increment.
// Priority: reset > load > inc. Increment wraps modulo 2**ADDR_W.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears pc to 0
//   load       load pc from load_addr (redirect)
//   load_addr  redirect target
//   inc        advance pc by one word
//   pc         current program counter
// ---------------------------------------------------------------------------
module pc_reg #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset)
      pc <= '0;
    else if (load)
      pc <= load_addr;
    else if (inc)
      pc <= pc + ADDR_W'(1);
  end

endmodule

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch engine: sequences synchronous IRAM reads from the PC,
// assembles WORDS_PER_INSTR words into one instruction and offers it
// downstream on a valid/ready handshake.
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         pulse: set run flag, begin fetching at current PC
//   halt          pulse: clear run flag; FSM idles at next instruction boundary
//   jump_en       redirect PC to jump_addr, discarding any partial instruction
//   jump_addr     redirect target
//   mem_rd_en     IRAM read strobe
//   mem_addr      IRAM address (= PC)
//   mem_rdata     IRAM data, valid one cycle after mem_rd_en
//   instr_valid   instr_out/instr_pc hold a complete instruction
//   instr_ready   downstream accept
//   instr_out     assembled instruction, lowest-address word in the low bits
//   instr_pc      address of the instruction's first word
//   pc_out        current PC
//   busy          FSM not idle
// ---------------------------------------------------------------------------
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter  int ADDR_W          = 8,
  parameter  int DATA_W          = 8,
  parameter  int WORDS_PER_INSTR = 2,
  localparam int INSTR_W         = instr_width(DATA_W, WORDS_PER_INSTR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               halt,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               mem_rd_en,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               busy
);

  localparam int               CNT_W    = cnt_width(WORDS_PER_INSTR);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_INSTR - 1);

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              run;
  logic              run_next;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] pc;
  logic              handshake;

  assign handshake = instr_valid & instr_ready;

  // halt beats start when both arrive together
  assign run_next = halt ? 1'b0 : (start ? 1'b1 : run);

  // A redirect cycle issues no read, so the PC only advances on a plain fetch.
  assign mem_rd_en = (state == S_FETCH) && !jump_en;
  assign mem_addr  = pc;
  assign pc_out    = pc;
  assign busy      = (state != S_IDLE);

  pc_reg #(.ADDR_W(ADDR_W)) u_pc_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (jump_en),
    .load_addr (jump_addr),
    .inc       (mem_rd_en),
    .pc        (pc)
  );

  always_comb begin
    state_next = state;
    if (jump_en) begin
      state_next = run_next ? S_FETCH : S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (run_next) state_next = S_FETCH;
        S_FETCH: state_next = S_CAPT;
        S_CAPT:  state_next = (cnt == LAST_CNT) ? S_HOLD : S_FETCH;
        S_HOLD:  if (handshake) state_next = run_next ? S_FETCH : S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // The assembly buffer doubles as instr_out: slots fill in place and the
  // word is only advertised once the last slot lands, so instr_out is
  // stable throughout HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      run         <= 1'b0;
      cnt         <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      instr_pc    <= '0;
    end else begin
      state <= state_next;
      run   <= run_next;
      if (jump_en) begin
        // Partial or held instruction is abandoned; returning data is ignored.
        cnt         <= '0;
        instr_valid <= 1'b0;
      end else begin
        case (state)
          S_FETCH: begin
            if (cnt == '0)
              instr_pc <= pc;
          end
          S_CAPT: begin
            instr_out[cnt*DATA_W +: DATA_W] <= mem_rdata;
            if (cnt == LAST_CNT) begin
              cnt         <= '0;
              instr_valid <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          S_HOLD: begin
            if (handshake)
              instr_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit (ADDR_W=8, DATA_W=8, WORDS_PER_INSTR=2).
// IRAM model: mem[a] = a ^ 8'hA5, read data registered one cycle after the
// strobe; random garbage is driven whenever no read is pending.
// Inputs change on the falling edge; outputs are sampled 4ns later, one ns
// before the next rising edge, so each sample shows the cycle's settled state.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        halt;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_out;
  logic [7:0]  instr_pc;
  logic [7:0]  pc_out;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(8), .DATA_W(8), .WORDS_PER_INSTR(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .halt        (halt),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .pc_out      (pc_out),
    .busy        (busy)
  );

  function automatic logic [7:0] mem_word(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // Reference instruction: two consecutive words from pc, wrapping at 8 bits.
  function automatic logic [15:0] model_instr(input logic [7:0] pc);
    logic [7:0] nxt;
    nxt = pc + 8'd1;
    return {mem_word(nxt), mem_word(pc)};
  endfunction

  always @(posedge clk)
    mem_rdata <= mem_rd_en ? mem_word(mem_addr) : 8'($urandom);

  task automatic apply_stimulus(input logic r, input logic st, input logic hl,
                                input logic je, input logic [7:0] ja, input logic rdy);
    @(negedge clk);
    reset       = r;
    start       = st;
    halt        = hl;
    jump_en     = je;
    jump_addr   = ja;
    instr_ready = rdy;
    #4;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle_cycle(input logic rdy);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, rdy);
  endtask

  // Stall with ready low until a complete instruction is offered.
  task automatic wait_valid(input string name, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      idle_cycle(1'b0);
    end
    check_output({name, "_timeout"}, 32'(ok), 32'd1);
  endtask

  // Handshake the offered instruction, then step into the following cycle.
  task automatic accept();
    idle_cycle(1'b1);
    idle_cycle(1'b0);
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic        e_valid;
    logic        e_rden;
    logic [7:0]  e_addr;
    logic [7:0]  e_pc;
    logic        e_busy;
    logic [15:0] e_out;
    logic [7:0]  e_ipc;
  } vec_t;

  vec_t tbl[18];

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  exp_pc;
    logic        prev_hold;
    logic [15:0] prev_out;
    logic [7:0]  prev_ipc;
    logic        r_rdy;
    logic        r_je;
    logic [7:0]  r_ja;
    int          n_hs;

    reset = 1'b1; start = 1'b0; halt = 1'b0; jump_en = 1'b0;
    jump_addr = 8'h00; instr_ready = 1'b0;

    // start at cycle 0, two back-to-back instructions, then a 6-cycle stall
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 16'h0000, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 16'h0000, 8'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1, 16'h0000, 8'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h01, 1'b1, 16'h0000, 8'h00};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1, 16'h0000, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h02, 1'b1, 16'hA4A5, 8'h00};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 8'h02, 1'b1, 16'h0000, 8'h00};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h03, 1'b1, 16'h0000, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 8'h03, 1'b1, 16'h0000, 8'h00};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h04, 1'b1, 16'h0000, 8'h00};
    for (int i = 10; i < 16; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h04, 1'b1, 16'hA6A7, 8'h02};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h04, 1'b1, 16'hA6A7, 8'h02};
    tbl[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h04, 8'h04, 1'b1, 16'h0000, 8'h00};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      apply_stimulus(1'b0, tbl[i].start, 1'b0, 1'b0, 8'h00, tbl[i].ready);
      check_output($sformatf("tbl%0d_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
      check_output($sformatf("tbl%0d_rden", i),  32'(mem_rd_en),   32'(tbl[i].e_rden));
      check_output($sformatf("tbl%0d_pc", i),    32'(pc_out),      32'(tbl[i].e_pc));
      check_output($sformatf("tbl%0d_busy", i),  32'(busy),        32'(tbl[i].e_busy));
      if (tbl[i].e_rden)
        check_output($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      if (tbl[i].e_valid || i == 0) begin
        check_output($sformatf("tbl%0d_out", i), 32'(instr_out), 32'(tbl[i].e_out));
        check_output($sformatf("tbl%0d_ipc", i), 32'(instr_pc),  32'(tbl[i].e_ipc));
      end
    end

    // jump while capturing word 0: partial instruction dropped
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycle(1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b0);
    check_output("jcapt_rden", 32'(mem_rd_en), 32'd0);
    idle_cycle(1'b0);
    check_output("jcapt_addr", 32'(mem_addr), 32'h40);
    wait_valid("jcapt", 40);
    check_output("jcapt_out", 32'(instr_out), 32'hE4E5);
    check_output("jcapt_ipc", 32'(instr_pc),  32'h40);
    accept();

    // jump to the top of memory during FETCH: PC wraps inside the instruction
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
    check_output("jff_rden", 32'(mem_rd_en), 32'd0);
    wait_valid("jff1", 40);
    check_output("jff_out1", 32'(instr_out), 32'hA55A);
    check_output("jff_ipc1", 32'(instr_pc),  32'hFF);
    accept();
    wait_valid("jff2", 40);
    check_output("jff_out2", 32'(instr_out), 32'hA7A4);
    check_output("jff_ipc2", 32'(instr_pc),  32'h01);
    accept();

    // halt during FETCH of word 1: instruction completes, then idle
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    check_output("halt_rden", 32'(mem_rd_en), 32'd1);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    check_output("halt_valid", 32'(instr_valid), 32'd1);
    check_output("halt_out",   32'(instr_out),   32'hA4A5);
    idle_cycle(1'b0);
    check_output("halt_busy",  32'(busy),        32'd0);
    check_output("halt_pc",    32'(pc_out),      32'h02);
    check_output("halt_vld0",  32'(instr_valid), 32'd0);
    idle_cycle(1'b0);
    check_output("halt_rden2", 32'(mem_rd_en),   32'd0);
    check_output("halt_busy2", 32'(busy),        32'd0);

    // jump while idle loads the PC but does not start fetching
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
    idle_cycle(1'b0);
    check_output("ijmp_pc",   32'(pc_out),    32'h33);
    check_output("ijmp_busy", 32'(busy),      32'd0);
    check_output("ijmp_rden", 32'(mem_rd_en), 32'd0);

    // reset while holding a valid instruction; then start+halt together
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    wait_valid("rst", 40);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    check_output("rst_valid", 32'(instr_valid), 32'd0);
    check_output("rst_pc",    32'(pc_out),      32'h00);
    check_output("rst_busy",  32'(busy),        32'd0);
    idle_cycle(1'b0);
    check_output("sh_busy",   32'(busy),        32'd0);
    check_output("sh_rden",   32'(mem_rd_en),   32'd0);

    // randomized ready/jump traffic against an instruction-stream model
    do_reset();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    exp_pc    = 8'h00;
    prev_hold = 1'b0;
    prev_out  = '0;
    prev_ipc  = '0;
    n_hs      = 0;
    for (int i = 0; i < 1500; i++) begin
      r_rdy = 1'($urandom_range(0, 1));
      r_je  = ($urandom_range(0, 31) == 0);
      r_ja  = 8'($urandom);
      apply_stimulus(1'b0, 1'b0, 1'b0, r_je, r_ja, r_rdy);
      if (prev_hold) begin
        check_output("rnd_hold_valid", 32'(instr_valid), 32'd1);
        check_output("rnd_hold_out",   32'(instr_out),   32'(prev_out));
        check_output("rnd_hold_ipc",   32'(instr_pc),    32'(prev_ipc));
      end
      if (instr_valid && r_rdy) begin
        check_output("rnd_ipc", 32'(instr_pc),  32'(exp_pc));
        check_output("rnd_out", 32'(instr_out), 32'(model_instr(exp_pc)));
        exp_pc = exp_pc + 8'd2;
        n_hs++;
      end
      if (r_je) begin
        check_output("rnd_jmp_rden", 32'(mem_rd_en), 32'd0);
        exp_pc = r_ja;
      end
      prev_hold = instr_valid && !r_rdy && !r_je;
      prev_out  = instr_out;
      prev_ipc  = instr_pc;
    end
    check_output("rnd_progress", 32'(n_hs > 100), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
